// File: rtl/jtframe_rom_arb_pkg.sv
// Shared types and helpers for the SDRAM ROM-slot arbiter.
package jtframe_rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    // Slot index width; at least one bit so a single-slot build still has a select.
    function automatic int slot_iw(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/jtframe_rom_arb_slot.sv
// One client slot: a single-word tag/data cache with hit detection,
// flush, download invalidation and fill from the arbiter.
module jtframe_rom_arb_slot
    import jtframe_rom_arb_pkg::*;
#(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          downloading,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          flush,
    input  logic          busy,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data,
    output logic          ok,
    output logic [DW-1:0] dout,
    output logic          miss
);

    logic          valid_reg;
    logic [AW-1:0] tag_reg;
    logic [DW-1:0] data_reg;
    logic          hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
            data_reg  <= '0;
        end else begin
            if (fill) begin
                tag_reg  <= fill_addr;
                data_reg <= fill_data;
            end
            // Invalidation beats a coincident fill, so a discarded fill never shows as valid.
            if (downloading || flush)
                valid_reg <= 1'b0;
            else if (fill)
                valid_reg <= 1'b1;
        end
    end

    assign hit  = cs && valid_reg && (tag_reg == addr);
    assign ok   = hit;
    assign dout = data_reg;
    assign miss = cs && !hit && !busy;

endmodule

// File: rtl/jtframe_rom_arb.sv
// Arbitrates N cached ROM read slots onto one SDRAM read port using the
// req/ack/dst/rdy handshake, with fixed-priority or round-robin selection.
module jtframe_rom_arb
    import jtframe_rom_arb_pkg::*;
#(
    parameter int SLOTS = 9,
    parameter int AW    = 22,
    parameter int DW    = 32,
    parameter int RR    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    input  logic [SLOTS-1:0]    slot_flush,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_dst,
    input  logic                data_rdy,
    input  logic [DW-1:0]       data_read
);

    localparam int IW = slot_iw(SLOTS);

    arb_state_t    state_reg;
    logic [IW-1:0] sel_reg;
    logic [IW-1:0] ptr_reg;
    logic [AW-1:0] sel_addr_reg;
    logic          req_reg;

    logic [SLOTS-1:0] miss;
    logic [SLOTS-1:0] busy;
    logic [SLOTS-1:0] fill;
    logic [AW-1:0]    addr_arr [SLOTS];
    logic             found_next;
    logic [IW-1:0]    win_next;

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            assign addr_arr[gi] = slot_addr[gi*AW +: AW];
            assign busy[gi]     = (state_reg != IDLE) && (sel_reg == IW'(gi));
            assign fill[gi]     = (state_reg == WAIT) && data_dst && (sel_reg == IW'(gi));

            jtframe_rom_arb_slot #(
                .AW (AW),
                .DW (DW)
            ) u_slot (
                .clk         (clk),
                .rst_n       (rst_n),
                .downloading (downloading),
                .cs          (slot_cs[gi]),
                .addr        (addr_arr[gi]),
                .flush       (slot_flush[gi]),
                .busy        (busy[gi]),
                .fill        (fill[gi]),
                .fill_addr   (sel_addr_reg),
                .fill_data   (data_read),
                .ok          (slot_ok[gi]),
                .dout        (slot_dout[gi*DW +: DW]),
                .miss        (miss[gi])
            );
        end
    endgenerate

    // Search starts at ptr in round-robin mode and at slot 0 otherwise, wrapping once.
    always_comb begin
        int idx;
        found_next = 1'b0;
        win_next   = '0;
        idx        = 0;
        for (int i = 0; i < SLOTS; i++) begin
            idx = ((RR != 0) ? int'(ptr_reg) : 0) + i;
            if (idx >= SLOTS)
                idx = idx - SLOTS;
            if (!found_next && miss[idx]) begin
                found_next = 1'b1;
                win_next   = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            sel_reg      <= '0;
            ptr_reg      <= '0;
            sel_addr_reg <= '0;
            req_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (found_next && !downloading) begin
                        sel_reg      <= win_next;
                        sel_addr_reg <= addr_arr[win_next];
                        req_reg      <= 1'b1;
                        state_reg    <= REQ;
                        if (RR != 0 && SLOTS > 1)
                            ptr_reg <= (win_next == IW'(SLOTS-1)) ? '0 : win_next + 1'b1;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        req_reg   <= 1'b0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (data_rdy)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sdram_req  = req_reg;
    assign sdram_addr = sel_addr_reg;

endmodule
